xmem_hbridge: RTL

Downstream adapter for the service processor's 32-bit external-memory port (`xmem_*`, classic Wishbone, word addressed). It converts each 32-bit access into one or two 16-bit half-word beats on a shared memory-controller port (`mem_*`, classic Wishbone). It also keeps a single-entry read buffer so repeated reads of the same word complete without touching memory. Big-endian bit numbering throughout: bit 0 is the MSB.

---
 rtl/xmem_hbridge.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/xmem_hbridge.sv
// Splits 32-bit word accesses from the service processor into one or two
// 16-bit half-word beats on the memory controller, with a one-entry read buffer.
module xmem_hbridge #(
  parameter int mem_addr_width = 24,
  parameter bit enable_rbuf    = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [2:31]                 xmem_adr_i,
  input  logic [0:31]                 xmem_dat_i,
  output logic [0:31]                 xmem_dat_o,
  input  logic                        xmem_we_i,
  input  logic [0:3]                  xmem_sel_i,
  input  logic                        xmem_stb_i,
  input  logic                        xmem_cyc_i,
  output logic                        xmem_ack_o,
  output logic [0:mem_addr_width-1]   mem_adr_o,
  output logic [0:15]                 mem_dat_o,
  input  logic [0:15]                 mem_dat_i,
  output logic                        mem_we_o,
  output logic [0:1]                  mem_sel_o,
  output logic                        mem_stb_o,
  output logic                        mem_cyc_o,
  input  logic                        mem_ack_i
);

  localparam int ALO = 33 - mem_addr_width;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, ACK} state_t;
  state_t state, state_nxt;

  logic [2:31]                 adr_q;
  logic                        we_q;
  logic [0:3]                  sel_q;
  logic [0:31]                 wdat_q;
  logic [0:15]                 rhi_q;
  logic                        abort_q;
  logic                        rbuf_vld;
  logic [2:31]                 rbuf_tag;
  logic [0:31]                 rbuf_dat;
  logic                        req;
  logic                        hit;
  logic [0:mem_addr_width-2]   cur_hadr;
  logic                        cur_we;
  logic [0:3]                  cur_sel;
  logic [0:31]                 cur_wdat;

  // In IDLE the beat registers load straight from the request being accepted.
  always_comb begin
    req      = xmem_cyc_i & xmem_stb_i;
    hit      = enable_rbuf && rbuf_vld && (rbuf_tag == xmem_adr_i) && !xmem_we_i;
    cur_hadr = (state == IDLE) ? xmem_adr_i[ALO:31] : adr_q[ALO:31];
    cur_we   = (state == IDLE) ? xmem_we_i  : we_q;
    cur_sel  = (state == IDLE) ? xmem_sel_i : sel_q;
    cur_wdat = (state == IDLE) ? xmem_dat_i : wdat_q;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (!xmem_we_i)             state_nxt = hit ? ACK : BEAT0;
          else if (|xmem_sel_i[0:1])  state_nxt = BEAT0;
          else if (|xmem_sel_i[2:3])  state_nxt = BEAT1;
          else                        state_nxt = ACK;
        end
      end
      BEAT0: begin
        if (mem_ack_i)
          state_nxt = (we_q && (sel_q[2:3] == 2'b00)) ? ACK : BEAT1;
      end
      BEAT1: begin
        if (mem_ack_i) state_nxt = ACK;
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xmem_ack_o <= 1'b0;
      xmem_dat_o <= '0;
      mem_stb_o  <= 1'b0;
      mem_cyc_o  <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_sel_o  <= '0;
      mem_adr_o  <= '0;
      mem_dat_o  <= '0;
      rbuf_vld   <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      mem_stb_o  <= (state_nxt == BEAT0) || (state_nxt == BEAT1);
      mem_cyc_o  <= (state_nxt == BEAT0) || (state_nxt == BEAT1);
      xmem_ack_o <= 1'b0;
      // A cyc drop seen during the beats suppresses the ack even if cyc returns.
      if (state_nxt == ACK)
        xmem_ack_o <= xmem_cyc_i && ((state == IDLE) || !abort_q);

      if (state_nxt == BEAT0) begin
        mem_adr_o <= {cur_hadr, 1'b0};
        mem_dat_o <= cur_wdat[0:15];
        mem_sel_o <= cur_we ? cur_sel[0:1] : 2'b11;
      end else if (state_nxt == BEAT1) begin
        mem_adr_o <= {cur_hadr, 1'b1};
        mem_dat_o <= cur_wdat[16:31];
        mem_sel_o <= cur_we ? cur_sel[2:3] : 2'b11;
      end

      case (state)
        IDLE: begin
          if (req) begin
            adr_q    <= xmem_adr_i;
            we_q     <= xmem_we_i;
            sel_q    <= xmem_sel_i;
            wdat_q   <= xmem_dat_i;
            abort_q  <= 1'b0;
            mem_we_o <= xmem_we_i;
            if (xmem_we_i && (rbuf_tag == xmem_adr_i)) rbuf_vld <= 1'b0;
            if (hit) xmem_dat_o <= rbuf_dat;
          end
        end
        BEAT0: begin
          if (!xmem_cyc_i) abort_q <= 1'b1;
          if (mem_ack_i)   rhi_q   <= mem_dat_i;
        end
        BEAT1: begin
          if (!xmem_cyc_i) abort_q <= 1'b1;
          if (mem_ack_i && !we_q) begin
            xmem_dat_o <= {rhi_q, mem_dat_i};
            rbuf_vld   <= 1'b1;
            rbuf_tag   <= adr_q;
            rbuf_dat   <= {rhi_q, mem_dat_i};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
